// File: rtl/ysyx_23060077_riscv_ifq.sv
// Instruction fetch queue: circular buffer between fetch and decode.
// Drops bubbles on entry and predecodes control-flow opcodes at write time.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module ysyx_23060077_riscv_ifq #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [`INST_WIDTH-1:0] in_pc,
   input  logic [`INST_WIDTH-1:0] in_inst,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [`INST_WIDTH-1:0] out_pc,
   output logic [`INST_WIDTH-1:0] out_inst,
   output logic                   out_ctrl_flow,
   output logic [PTR_W:0]         count
);

   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic [`INST_WIDTH-1:0] pc_mem   [DEPTH];
   logic [`INST_WIDTH-1:0] inst_mem [DEPTH];
   logic                   cf_mem   [DEPTH];

   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W:0]   count_reg, count_next;

   logic push;
   logic pop;
   logic in_is_bubble;
   logic in_ctrl_flow;

   // Handshake terms depend on registered occupancy only, never on out_ready/flush.
   assign in_ready     = (count_reg != FULL_COUNT);
   assign out_valid    = (count_reg != '0);
   assign in_is_bubble = (in_inst == '0);
   assign push         = in_valid && in_ready && !flush && !in_is_bubble;
   assign pop          = out_valid && out_ready && !flush;

   assign in_ctrl_flow = (in_inst[6:0] == OP_JAL)  ||
                         (in_inst[6:0] == OP_JALR) ||
                         (in_inst[6:0] == OP_BRANCH);

   always_comb begin
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      count_next  = count_reg;
      if (flush) begin
         rd_ptr_next = '0;
         wr_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
         end
         unique case ({push, pop})
            2'b10:   count_next = count_reg + COUNT_ONE;
            2'b01:   count_next = count_reg - COUNT_ONE;
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Payload storage is left unreset; the output mux below hides it while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_reg]   <= in_pc;
         inst_mem[wr_ptr_reg] <= in_inst;
         cf_mem[wr_ptr_reg]   <= in_ctrl_flow;
      end
   end

   always_comb begin
      out_pc        = '0;
      out_inst      = '0;
      out_ctrl_flow = 1'b0;
      if (out_valid) begin
         out_pc        = pc_mem[rd_ptr_reg];
         out_inst      = inst_mem[rd_ptr_reg];
         out_ctrl_flow = cf_mem[rd_ptr_reg];
      end
   end

   assign count = count_reg;

endmodule

// File: tb/tb_ysyx_23060077_riscv_ifq.sv
// Bench for the fetch queue: directed scenarios then random traffic,
// all checked against a queue-based reference model.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module tb_ysyx_23060077_riscv_ifq;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_ctrl_flow;
   logic [PTR_W:0] count;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t model_q[$];

   ysyx_23060077_riscv_ifq #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_pc        (in_pc),
      .in_inst      (in_inst),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_inst     (out_inst),
      .out_ctrl_flow(out_ctrl_flow),
      .count        (count)
   );

   always #5 clk = ~clk;

   function automatic logic is_ctrl(input logic [31:0] inst);
      return (inst[6:0] == 7'h6F) || (inst[6:0] == 7'h67) || (inst[6:0] == 7'h63);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Compare every output against what the model says the queue holds now.
   task automatic check_outputs(input string where);
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic        e_cf;
      e_pc = 32'h0; e_inst = 32'h0; e_cf = 1'b0;
      if (model_q.size() != 0) begin
         e_pc   = model_q[0].pc;
         e_inst = model_q[0].inst;
         e_cf   = is_ctrl(model_q[0].inst);
      end
      chk({where, ".count"},     32'(count),         32'(model_q.size()));
      chk({where, ".out_valid"}, 32'(out_valid),     32'(model_q.size() != 0));
      chk({where, ".in_ready"},  32'(in_ready),      32'(model_q.size() != DEPTH));
      chk({where, ".out_pc"},    out_pc,             e_pc);
      chk({where, ".out_inst"},  out_inst,           e_inst);
      chk({where, ".out_cf"},    32'(out_ctrl_flow), 32'(e_cf));
   endtask

   // One clock cycle: drive, check mid-cycle, advance model at the edge.
   task automatic cyc(input string where, input logic v, input logic [31:0] pc,
                      input logic [31:0] inst, input logic fl, input logic ordy);
      bit do_push;
      bit do_pop;
      in_valid = v; in_pc = pc; in_inst = inst; flush = fl; out_ready = ordy;
      #4;
      check_outputs(where);
      do_push = v && (model_q.size() < DEPTH) && !fl && (inst != 32'h0);
      do_pop  = (model_q.size() != 0) && ordy && !fl;
      @(posedge clk);
      if (fl) begin
         model_q.delete();
         $display("[%0t] %s flush", $time, where);
      end else begin
         if (do_pop) begin
            $display("[%0t] %s pop  pc=%h inst=%h", $time, where, model_q[0].pc, model_q[0].inst);
            void'(model_q.pop_front());
         end
         if (do_push) begin
            model_q.push_back('{pc: pc, inst: inst});
            $display("[%0t] %s push pc=%h inst=%h", $time, where, pc, inst);
         end
      end
      #1;
   endtask

   task automatic idle(input string where);
      cyc(where, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] ri;

      rst = 1'b1;
      in_valid = 1'b1; in_pc = 32'h1234; in_inst = 32'h13; flush = 1'b0; out_ready = 1'b0;
      #3;
      check_outputs("reset_async");
      #9;
      check_outputs("reset_held");
      in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      // Three pushes with decode stalled; head must hold.
      for (int i = 0; i < 3; i++)
         cyc("fill3", 1'b1, 32'h80000000 + 32'(4*i), 32'h00000013, 1'b0, 1'b0);
      idle("fill3_hold");
      idle("fill3_hold");
      chk("fill3_head", out_pc, 32'h80000000);

      // Fill to full, offer a fifth, then one pop.
      cyc("full", 1'b1, 32'h8000000C, 32'h00000013, 1'b0, 1'b0);
      cyc("full5", 1'b1, 32'h80000010, 32'h00000013, 1'b0, 1'b0);
      chk("full_in_ready", 32'(in_ready), 32'h0);
      cyc("full_pop", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      idle("after_pop");
      chk("after_pop_count", 32'(count), 32'h3);

      // Drain, then bubble between two valid pushes.
      for (int i = 0; i < 3; i++) cyc("drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      cyc("bub_a", 1'b1, 32'h80000000, 32'h00000013, 1'b0, 1'b0);
      cyc("bub_0", 1'b1, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
      cyc("bub_b", 1'b1, 32'h80000004, 32'h00000013, 1'b0, 1'b0);
      chk("bub_count", 32'(count), 32'h2);
      cyc("bub_pop1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      cyc("bub_pop2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

      // Flush with a same-cycle push and pop, then a jump lands as head.
      for (int i = 0; i < 3; i++)
         cyc("pre_flush", 1'b1, 32'h80000020 + 32'(4*i), 32'h00000013, 1'b0, 1'b0);
      cyc("flush", 1'b1, 32'h80000040, 32'h0000006F, 1'b1, 1'b1);
      chk("flush_out_valid", 32'(out_valid), 32'h0);
      cyc("flush2", 1'b1, 32'h80000044, 32'h00000013, 1'b1, 1'b0);
      cyc("post_flush", 1'b1, 32'h80000100, 32'h0000006F, 1'b0, 1'b0);
      chk("post_flush_cf", 32'(out_ctrl_flow), 32'h1);
      cyc("post_flush_pop", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

      // Full-throughput streaming with one entry in flight; pointers wrap.
      cyc("stream_seed", 1'b1, 32'h80000200, 32'h00000013, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++)
         cyc("stream", 1'b1, 32'h80000200 + 32'(4*i), 32'h00000063, 1'b0, 1'b1);
      chk("stream_count", 32'(count), 32'h1);
      chk("stream_head", out_pc, 32'h80000228);
      cyc("stream_drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

      // Asynchronous reset mid-cycle with two entries queued.
      cyc("pre_rst", 1'b1, 32'h80000300, 32'h00000013, 1'b0, 1'b0);
      cyc("pre_rst", 1'b1, 32'h80000304, 32'h00000013, 1'b0, 1'b0);
      in_valid = 1'b0; out_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      model_q.delete();
      check_outputs("async_rst");
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      cyc("rst_push", 1'b1, 32'h80000000, 32'h00000013, 1'b0, 1'b0);
      idle("rst_head");
      chk("rst_head_pc", out_pc, 32'h80000000);

      // Random traffic: bubbles, control-flow opcodes, stalls and occasional flushes.
      for (int n = 0; n < 400; n++) begin
         r = $urandom;
         case ($urandom_range(0, 5))
            0:       ri = 32'h0;
            1:       ri = {r[31:7], 7'h6F};
            2:       ri = {r[31:7], 7'h67};
            3:       ri = {r[31:7], 7'h63};
            default: ri = r | 32'h1;
         endcase
         cyc("rand", ($urandom_range(0, 3) != 0), {$urandom} & 32'hFFFF_FFFC, ri,
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation did not finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
